// File: rtl/sbox_share_sched.sv
// sbox_share_sched: shares LANES AES Sbox instances between SubBytes over the
// state and SubWord over a key word, one beat of LANES bytes per cycle.
module sbox_share_sched #(
   parameter int BYTE     = 8,
   parameter int WORD     = 32,
   parameter int SENTENCE = 128,
   parameter int LANES    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                st_start,
   input  logic [SENTENCE-1:0] st_in,
   output logic                st_ready,
   output logic                st_done,
   output logic [SENTENCE-1:0] st_out,
   input  logic                kw_req,
   input  logic [WORD-1:0]     kw_in,
   output logic                kw_ack,
   output logic [WORD-1:0]     kw_out
);
   localparam int LB = BYTE * LANES;
   localparam int N  = SENTENCE / LB;
   localparam int M  = WORD / LB;
   localparam int SW = (N > 1) ? $clog2(N) : 1;
   localparam int KW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic {S_IDLE, S_RUN} st_e;
   typedef enum logic {K_IDLE, K_RUN} kt_e;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] t, r;
      t = x;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         t = gmul(t, t);
         r = gmul(r, t);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   st_e                 st_q;
   kt_e                 kt_q;
   logic [SW-1:0]       scnt_q;
   logic [KW-1:0]       kcnt_q;
   logic                klast_q, st_done_q, kw_ack_q;
   logic [SENTENCE-1:0] sin_q, sin_d, st_out_q;
   logic [WORD-1:0]     kin_q, kin_d, kw_out_q;
   logic [LB-1:0]       lane_in, sub;
   logic                st_run, k_run, k_gnt, s_gnt, s_last, k_last, s_acc, k_acc;

   assign st_run = st_q == S_RUN;
   assign k_run  = kt_q == K_RUN;
   // The cycle right after a key job's last beat always goes to a running state job.
   assign k_gnt  = k_run && !(klast_q && st_run);
   assign s_gnt  = st_run && !k_gnt;
   assign s_last = s_gnt && scnt_q == SW'(N - 1);
   assign k_last = k_gnt && kcnt_q == KW'(M - 1);
   assign s_acc  = st_start && !st_run;
   assign k_acc  = kw_req && !k_run && !kw_ack_q;

   assign lane_in = k_gnt ? kin_q[int'(kcnt_q) * LB +: LB]
                  : s_gnt ? sin_q[int'(scnt_q) * LB +: LB] : '0;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign sub[j * BYTE +: BYTE] = sbox(lane_in[j * BYTE +: BYTE]);
   end

   // Working registers double as result registers: each beat overwrites its bytes.
   always_comb begin
      sin_d = sin_q;
      kin_d = kin_q;
      if (s_gnt) sin_d[int'(scnt_q) * LB +: LB] = sub;
      if (k_gnt) kin_d[int'(kcnt_q) * LB +: LB] = sub;
      if (s_acc) sin_d = st_in;
      if (k_acc) kin_d = kw_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= S_IDLE;
         kt_q      <= K_IDLE;
         scnt_q    <= '0;
         kcnt_q    <= '0;
         klast_q   <= 1'b0;
         st_done_q <= 1'b0;
         kw_ack_q  <= 1'b0;
         sin_q     <= '0;
         kin_q     <= '0;
         st_out_q  <= '0;
         kw_out_q  <= '0;
      end else begin
         sin_q     <= sin_d;
         kin_q     <= kin_d;
         klast_q   <= k_last;
         st_done_q <= s_last;
         kw_ack_q  <= k_last;
         if (s_acc) begin
            st_q   <= S_RUN;
            scnt_q <= '0;
         end else if (s_last) begin
            st_q     <= S_IDLE;
            st_out_q <= sin_d;
         end else if (s_gnt) begin
            scnt_q <= scnt_q + 1'b1;
         end
         if (k_acc) begin
            kt_q   <= K_RUN;
            kcnt_q <= '0;
         end else if (k_last) begin
            kt_q     <= K_IDLE;
            kw_out_q <= kin_d;
         end else if (k_gnt) begin
            kcnt_q <= kcnt_q + 1'b1;
         end
      end
   end

   assign st_ready = !st_run;
   assign st_done  = st_done_q;
   assign st_out   = st_out_q;
   assign kw_ack   = kw_ack_q;
   assign kw_out   = kw_out_q;
endmodule

// File: tb/tb_sbox_share_sched.sv
// tb_sbox_share_sched: vector table plus scoreboard queues for the shared Sbox
// scheduler at LANES=4, with LANES=1/2 instances for the beat-count cases.
module tb_sbox_share_sched;
   logic         clk = 1'b0, rst = 1'b1, st_start = 1'b0, kw_req = 1'b0;
   logic [127:0] st_in = '0;
   logic [31:0]  kw_in = '0;
   logic         st_ready4, st_done4, kw_ack4, st_ready2, st_done2, kw_ack2, st_ready1, st_done1, kw_ack1;
   logic [127:0] st_out4, st_out2, st_out1;
   logic [31:0]  kw_out4, kw_out2, kw_out1;
   int           n_chk = 0, n_fail = 0;
   logic [127:0] sq[$];
   logic [31:0]  kq[$];
   logic [7:0]   kin[33], kout[33];

   typedef struct {
      logic [127:0] s_in;
      logic [127:0] s_exp;
      logic [31:0]  k_in;
      logic [31:0]  k_exp;
   } vec_t;
   vec_t vt[6];

   sbox_share_sched #(.LANES(4)) d4 (.clk(clk), .rst(rst), .st_start(st_start), .st_in(st_in),
      .st_ready(st_ready4), .st_done(st_done4), .st_out(st_out4), .kw_req(kw_req), .kw_in(kw_in),
      .kw_ack(kw_ack4), .kw_out(kw_out4));
   sbox_share_sched #(.LANES(2)) d2 (.clk(clk), .rst(rst), .st_start(st_start), .st_in(st_in),
      .st_ready(st_ready2), .st_done(st_done2), .st_out(st_out2), .kw_req(kw_req), .kw_in(kw_in),
      .kw_ack(kw_ack2), .kw_out(kw_out2));
   sbox_share_sched #(.LANES(1)) d1 (.clk(clk), .rst(rst), .st_start(st_start), .st_in(st_in),
      .st_ready(st_ready1), .st_done(st_done1), .st_out(st_out1), .kw_req(kw_req), .kw_in(kw_in),
      .kw_ack(kw_ack1), .kw_out(kw_out1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] sb(input logic [7:0] b);
      for (int i = 0; i < 33; i++) if (kin[i] == b) return kout[i];
      return 8'h00;
   endfunction

   function automatic logic [127:0] sub128(input logic [127:0] x);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = sb(x[i*8 +: 8]);
      return r;
   endfunction

   function automatic logic [31:0] sub32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = sb(x[i*8 +: 8]);
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = kin[$urandom_range(0, 32)];
      return r;
   endfunction

   // Scoreboard: every done/ack pops the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (st_done4) begin
            if (sq.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL st_unexpected: got st_done expected none");
            end else chk("st_out", st_out4, sq.pop_front());
         end
         if (kw_ack4) begin
            if (kq.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL kw_unexpected: got kw_ack expected none");
            end else chk("kw_out", kw_out4, kq.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [127:0] exp5;
      int ack_c, done_c, nk;
      logic ack;
      kin  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0a,
               8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
               8'h70, 8'h80, 8'h90, 8'ha0, 8'hb0, 8'hc0, 8'hd0, 8'he0, 8'hf0, 8'h53, 8'hff};
      kout = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67,
               8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'hb7, 8'h04, 8'h09, 8'h53, 8'hd0,
               8'h51, 8'hcd, 8'h60, 8'he0, 8'he7, 8'hba, 8'h70, 8'he1, 8'h8c, 8'hed, 8'h16};
      vt[0].s_in = {16{8'hff}};
      vt[0].k_in = 32'h00000000;
      vt[1].s_in = 128'h0f0e0d0c0b0a09080706050403020100;
      vt[1].k_in = 32'hf0e0d0c0;
      for (int v = 2; v < 6; v++) begin
         vt[v].s_in = rnd128();
         vt[v].k_in = rnd128()[31:0];
      end
      for (int v = 0; v < 6; v++) begin
         vt[v].s_exp = sub128(vt[v].s_in);
         vt[v].k_exp = sub32(vt[v].k_in);
      end

      tick; tick; rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", st_ready4, 1'b1);
      chk("rst_done", st_done4, 1'b0);
      chk("rst_st_out", st_out4, '0);
      chk("rst_ack", kw_ack4, 1'b0);
      chk("rst_kw_out", kw_out4, '0);

      // All-zero state: done five cycles after start.
      tick; st_start = 1'b1; st_in = '0; sq.push_back({16{8'h63}});
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("t1_done", st_done4, c == 5);
         chk("t1_ready", st_ready4, (c == 0) || (c == 5));
         tick; st_start = 1'b0;
      end

      // Key word alone; request held through the ack cycle must not re-accept.
      kw_req = 1'b1; kw_in = 32'h010053ff; kq.push_back(32'h7c63ed16);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t2_ack", kw_ack4, c == 2);
         tick;
         if (c == 2) kw_req = 1'b0;
      end

      // Key job arriving mid-state-job preempts one beat.
      st_start = 1'b1; st_in = {16{8'h53}}; sq.push_back({16{8'hed}});
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk("t3_ack", kw_ack4, c == 3);
         chk("t3_done", st_done4, c == 6);
         tick;
         if (c == 0) begin
            st_start = 1'b0; kw_req = 1'b1; kw_in = 32'h00010203; kq.push_back(sub32(32'h00010203));
         end
         if (c == 3) kw_req = 1'b0;
      end

      // Back-to-back key jobs during a state job.
      st_start = 1'b1; st_in = rnd128(); sq.push_back(sub128(st_in));
      kw_req = 1'b1; kw_in = rnd128()[31:0]; kq.push_back(sub32(kw_in));
      nk = 1; done_c = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (st_done4) done_c = c;
         ack = kw_ack4;
         tick; st_start = 1'b0;
         if (ack) begin
            if (nk < 6) begin
               kw_in = rnd128()[31:0]; kq.push_back(sub32(kw_in)); nk++;
            end else kw_req = 1'b0;
         end
      end
      chk("t4_done_cycle", done_c, 7);
      chk("t4_keys_left", kq.size(), 0);

      // Narrower lane counts take more beats for the same state.
      rst = 1'b1; tick; tick; rst = 1'b0;
      exp5 = {{14{8'h63}}, 8'h7c, 8'h16};
      st_start = 1'b1; st_in = 128'h01ff; sq.push_back(exp5);
      for (int c = 0; c < 19; c++) begin
         @(negedge clk);
         chk("t5_l2_done", st_done2, c == 9);
         chk("t5_l1_done", st_done1, c == 17);
         if (c == 9) chk("t5_l2_out", st_out2, exp5);
         if (c == 17) chk("t5_l1_out", st_out1, exp5);
         tick; st_start = 1'b0;
      end

      // Reset during a state job discards it.
      st_start = 1'b1; st_in = {16{8'h53}};
      tick; st_start = 1'b0;
      tick; rst = 1'b1;
      tick; rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t6_no_done", st_done4, 1'b0);
         if (c == 0) begin
            chk("t6_st_out", st_out4, '0);
            chk("t6_ready", st_ready4, 1'b1);
         end
         tick;
      end

      // Table: simultaneous start and key request, key goes first.
      for (int v = 0; v < 6; v++) begin
         st_start = 1'b1; st_in = vt[v].s_in; sq.push_back(vt[v].s_exp);
         kw_req = 1'b1; kw_in = vt[v].k_in; kq.push_back(vt[v].k_exp);
         ack_c = -1; done_c = -1;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (kw_ack4) ack_c = c;
            if (st_done4) done_c = c;
            tick; st_start = 1'b0;
            if (ack_c >= 0) kw_req = 1'b0;
            if (done_c >= 0) break;
         end
         chk("tv_ack_cycle", ack_c, 2);
         chk("tv_done_cycle", done_c, 6);
      end
      kw_req = 1'b0;
      chk("st_queue_empty", sq.size(), 0);
      chk("kw_queue_empty", kq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
